// File: rtl/keypad_scanner_if.sv
// Pin-level keypad bundle: row strobes and column returns plus the debounced
// key event stream handed on to the safe controller.
interface keypad_scanner_if;
    logic       col1;
    logic       col2;
    logic       col3;
    logic       row1;
    logic       row2;
    logic       row3;
    logic       row4;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    modport master (
        input  col1, col2, col3,
        output row1, row2, row3, row4, key_valid, key_code, key_held
    );

    modport slave (
        output col1, col2, col3,
        input  row1, row2, row3, row4, key_valid, key_code, key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: rotates one-hot row strobes, debounces single-column
// presses and releases, and emits one-cycle key events with a 4-bit code.
module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    keypad_scanner_if.master kp
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       row_q, row_d;
    logic [1:0]       cap_row_q, cap_row_d;
    logic [2:0]       cap_col_q, cap_col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;

    logic [2:0] cols;
    logic       sample;
    logic       single;
    logic       none;
    logic [3:0] row_rot;
    logic [1:0] row_idx;

    assign cols    = {kp.col3, kp.col2, kp.col1};
    assign sample  = (div_q == DIV_W'(SCAN_DIV - 1));
    assign single  = $onehot(cols);
    assign none    = (cols == 3'b000);
    assign row_rot = {row_q[2:0], row_q[3]};

    always_comb begin
        row_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (row_q[i]) row_idx = 2'(i);
        end
    end

    // Rows 1-3 map to the digits 1..9; row 4 carries '*', '0' and '#'.
    function automatic logic [3:0] code_of(input logic [1:0] r, input logic [2:0] c);
        int ci;
        ci = c[2] ? 2 : (c[1] ? 1 : 0);
        if (r == 2'd3) begin
            case (ci)
                0:       code_of = 4'hA;
                1:       code_of = 4'h0;
                default: code_of = 4'hB;
            endcase
        end else begin
            code_of = 4'(3 * int'(r) + ci + 1);
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (sample) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        cap_row_d   = cap_row_q;
        cap_col_d   = cap_col_q;
        cnt_d       = cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;

        if (sample) begin
            case (state_q)
                ST_SCAN: begin
                    if (single) begin
                        state_d   = ST_DEBOUNCE;
                        cap_row_d = row_idx;
                        cap_col_d = cols;
                        cnt_d     = '0;
                    end else begin
                        row_d = row_rot;
                    end
                end
                ST_DEBOUNCE: begin
                    // cap_col_q is one-hot, so equality also implies a single column.
                    if (cols == cap_col_q) begin
                        if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                            key_valid_d = 1'b1;
                            key_code_d  = code_of(cap_row_q, cap_col_q);
                            state_d     = ST_HELD;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = ST_SCAN;
                        row_d   = row_rot;
                    end
                end
                ST_HELD: begin
                    if (none) begin
                        if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                            state_d = ST_SCAN;
                            row_d   = row_rot;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            row_q       <= 4'b0001;
            cap_row_q   <= '0;
            cap_col_q   <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cap_row_q   <= cap_row_d;
            cap_col_q   <= cap_col_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign kp.row1      = row_q[0];
    assign kp.row2      = row_q[1];
    assign kp.row3      = row_q[2];
    assign kp.row4      = row_q[3];
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_held  = (state_q == ST_HELD);
endmodule
